// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs bytes little-endian into a 32-bit word and pulses word_ready for one
// cycle once the fourth byte of a word has been shifted in.
//   clk, reset  : clock and synchronous active-high reset
//   clear       : synchronous restart (index and word back to zero)
//   push        : byte_data is accepted this cycle
//   byte_data   : incoming byte
//   word        : packed word (complete while word_ready is high)
//   lane        : byte index of the next byte within the current word
//   word_ready  : one-cycle pulse, word holds a complete word
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [1:0]  lane,
    output logic        word_ready
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    // Shift right so the first byte received ends up in bits 7:0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word       <= 32'd0;
            lane       <= 2'd0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= push && (lane == LAST_LANE);
            if (push) begin
                word <= {byte_data, word[31:8]};
                lane <= lane + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: receives a framed byte stream (count, payload,
// checksum), writes the payload into imem as consecutive 32-bit words and
// holds the processor in reset until the image checksum has been verified.
//   clk, reset         : clock and synchronous active-high reset
//   rx_valid, rx_data  : upstream byte stream
//   rx_ready           : byte accepted when rx_valid & rx_ready (state decode)
//   reload             : restart loading from DONE or ERROR
//   imem_we/addr/wd    : imem write port, one-cycle write pulse per word
//   cpu_reset          : processor reset, high until a verified image exists
//   done, error        : load complete / framing or checksum failure
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX_W     = $clog2(DEPTH) + 1;
    localparam logic [1:0]  LAST_LANE = 2'(BYTES_PER_WORD - 1);

    loader_state_t state, state_next;

    logic             accept;
    logic             restart;
    logic [7:0]       cnt_lo;
    logic [15:0]      word_cnt;
    logic [15:0]      hdr_count;
    logic             count_bad;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       sum;
    logic [1:0]       lane;
    logic             last_byte;
    logic             last_word;
    logic             done_next;
    logic             error_next;
    logic             cpu_reset_next;

    assign accept    = rx_valid && rx_ready;
    assign restart   = ((state == DONE) || (state == ERROR)) && reload;
    assign hdr_count = {rx_data, cnt_lo};
    assign count_bad = (hdr_count == 16'd0) || (hdr_count > 16'(DEPTH));
    assign last_byte = (lane == LAST_LANE);
    assign last_word = (16'(word_idx) == (word_cnt - 16'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            HDR0: if (accept) state_next = HDR1;
            HDR1: if (accept) state_next = count_bad ? ERROR : DATA;
            DATA: if (accept && last_byte && last_word) state_next = CSUM;
            CSUM: if (accept) state_next = (rx_data == sum) ? DONE : ERROR;
            DONE: if (reload) state_next = HDR0;
            ERROR: if (reload) state_next = HDR0;
            default: state_next = HDR0;
        endcase
    end

    // Output decode; status flags are derived from the upcoming state so the
    // registered copies change on the same edge as the state itself.
    always_comb begin
        rx_ready       = 1'b0;
        done_next      = 1'b0;
        error_next     = 1'b0;
        cpu_reset_next = 1'b1;
        case (state)
            HDR0, HDR1, DATA, CSUM: rx_ready = 1'b1;
            default:                rx_ready = 1'b0;
        endcase
        case (state_next)
            DONE: begin
                done_next      = 1'b1;
                cpu_reset_next = 1'b0;
            end
            ERROR: error_next = 1'b1;
            default: ;
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            done      <= done_next;
            error     <= error_next;
            cpu_reset <= cpu_reset_next;
        end
    end

    // Header capture, word counter, checksum and write address.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lo    <= 8'd0;
            word_cnt  <= 16'd0;
            word_idx  <= '0;
            sum       <= 8'd0;
            imem_addr <= 32'd0;
        end else if (restart) begin
            word_idx <= '0;
            sum      <= 8'd0;
        end else if (accept) begin
            case (state)
                HDR0: cnt_lo <= rx_data;
                HDR1: begin
                    word_cnt <= hdr_count;
                    word_idx <= '0;
                    sum      <= 8'd0;
                end
                DATA: begin
                    sum <= sum + rx_data;
                    // Address is latched alongside the packer's word_ready so
                    // both appear on the write port in the same cycle.
                    if (last_byte) begin
                        imem_addr <= 32'({word_idx, 2'b00});
                        word_idx  <= word_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .push       (accept && (state == DATA)),
        .byte_data  (rx_data),
        .word       (imem_wd),
        .lane       (lane),
        .word_ready (imem_we)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the
// directed frames plus a hand-written full-depth load.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    imem_loader #(.DEPTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one cycle, and outputs expected just after that edge.
    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  data;
        logic        rl;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        dn;
        logic        er;
        logic        cr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vld, input logic [7:0] d, input logic rl,
                       input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic dn, input logic er, input logic cr);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = d; v.rl = rl;
        v.we = we; v.addr = a; v.wd = wd;
        v.rdy = rdy; v.dn = dn; v.er = er; v.cr = cr;
        vecs.push_back(v);
    endtask

    // Byte accepted while loading, no write.
    task automatic ld(input logic [7:0] d);
        add(0, 1, d, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
    endtask
    // Byte completing a word: write visible after this edge.
    task automatic ld_w(input logic [7:0] d, input logic [31:0] a, input logic [31:0] wd);
        add(0, 1, d, 0, 1, a, wd, 1, 0, 0, 1);
    endtask
    task automatic to_done(input logic [7:0] d);
        add(0, 1, d, 0, 0, 32'd0, 32'd0, 0, 1, 0, 0);
    endtask
    task automatic to_err(input logic [7:0] d);
        add(0, 1, d, 0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
    endtask
    task automatic do_reload();
        add(0, 0, 8'h00, 1, 0, 32'd0, 32'd0, 1, 0, 0, 1);
    endtask
    task automatic do_reset(input logic vld, input logic [7:0] d);
        add(1, vld, d, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
    endtask

    task automatic check_outputs(input string name, input vec_t v);
        logic [3:0] got;
        logic [3:0] exp;
        got = {rx_ready, done, error, cpu_reset};
        exp = {v.rdy, v.dn, v.er, v.cr};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s status {rdy,done,err,cpu_rst}: got %b expected %b", name, got, exp);
        end
        checks++;
        if (imem_we !== v.we) begin
            errors++;
            $display("FAIL %s imem_we: got %b expected %b", name, imem_we, v.we);
        end
        if (v.we || v.rst) begin
            checks++;
            if (imem_addr !== v.addr || imem_wd !== v.wd) begin
                errors++;
                $display("FAIL %s write bus: got addr %h wd %h expected addr %h wd %h",
                         name, imem_addr, imem_wd, v.addr, v.wd);
            end
        end
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [7:0] d, input logic rl);
        @(negedge clk);
        reset    = rst;
        rx_valid = vld;
        rx_data  = d;
        reload   = rl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;

        // Reset values.
        do_reset(0, 8'h00);
        do_reset(1, 8'h55);

        // Single word.
        ld(8'h01); ld(8'h00);
        ld(8'h07); ld(8'h00); ld(8'hA0);
        ld_w(8'hE3, 32'h0, 32'hE3A00007);
        to_done(8'h8A);
        add(0, 0, 8'h00, 0, 0, 32'd0, 32'd0, 0, 1, 0, 0);
        // Byte offered while not ready is ignored.
        add(0, 1, 8'h12, 0, 0, 32'd0, 32'd0, 0, 1, 0, 0);
        do_reload();

        // Two words back to back, with a reload pulse ignored mid-frame.
        ld(8'h02); ld(8'h00);
        ld(8'h07); add(0, 1, 8'h00, 1, 0, 32'd0, 32'd0, 1, 0, 0, 1); ld(8'hA0);
        ld_w(8'hE3, 32'h0, 32'hE3A00007);
        ld(8'h64); ld(8'h00); ld(8'h80);
        ld_w(8'hE5, 32'h4, 32'hE5800064);
        to_done(8'h53);
        do_reload();

        // Bad checksum.
        ld(8'h02); ld(8'h00);
        ld(8'h07); ld(8'h00); ld(8'hA0);
        ld_w(8'hE3, 32'h0, 32'hE3A00007);
        ld(8'h64); ld(8'h00); ld(8'h80);
        ld_w(8'hE5, 32'h4, 32'hE5800064);
        to_err(8'h54);
        add(0, 1, 8'h53, 0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        do_reload();

        // Illegal counts: zero and DEPTH+1.
        ld(8'h00); to_err(8'h00);
        add(0, 1, 8'h07, 0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        do_reload();
        ld(8'h41); to_err(8'h00);
        do_reload();
        // Count with only the high byte set is also too large.
        ld(8'h00); to_err(8'h01);
        do_reload();

        // Gapped valid, single word.
        ld(8'h01);
        add(0, 0, 8'hFF, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
        ld(8'h00);
        add(0, 0, 8'hFF, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
        ld(8'h07);
        add(0, 0, 8'hFF, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
        ld(8'h00);
        add(0, 0, 8'hFF, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
        ld(8'hA0);
        add(0, 0, 8'hFF, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
        ld_w(8'hE3, 32'h0, 32'hE3A00007);
        add(0, 0, 8'hFF, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
        to_done(8'h8A);
        do_reload();
        // Second frame after reload: two words.
        ld(8'h02); ld(8'h00);
        ld(8'h07); ld(8'h00); ld(8'hA0);
        ld_w(8'hE3, 32'h0, 32'hE3A00007);
        ld(8'h64); ld(8'h00); ld(8'h80);
        ld_w(8'hE5, 32'h4, 32'hE5800064);
        to_done(8'h53);
        do_reload();

        // Reset after three payload bytes, offered together with the 4th byte.
        ld(8'h01); ld(8'h00);
        ld(8'h07); ld(8'h00); ld(8'hA0);
        do_reset(1, 8'hE3);
        add(0, 0, 8'h00, 0, 0, 32'd0, 32'd0, 1, 0, 0, 1);
        // Fresh frame.
        ld(8'h01); ld(8'h00);
        ld(8'h07); ld(8'h00); ld(8'hA0);
        ld_w(8'hE3, 32'h0, 32'hE3A00007);
        to_done(8'h8A);
        do_reload();

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].rl);
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Full-depth image (N = DEPTH), payload sum wraps many times.
        begin
            logic [7:0]  b;
            logic [7:0]  csum;
            logic [31:0] exp_wd;
            csum = 8'h00;
            drive(0, 1, 8'h40, 0);
            drive(0, 1, 8'h00, 0);
            checks++;
            if (error !== 1'b0 || rx_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_hdr: got err %b rdy %b expected err 0 rdy 1", error, rx_ready);
            end
            for (int w = 0; w < 64; w++) begin
                exp_wd = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    b = 8'(w * 4 + k) ^ 8'hA5;
                    csum = csum + b;
                    exp_wd[k*8 +: 8] = b;
                    drive(0, 1, b, 0);
                end
                checks++;
                if (imem_we !== 1'b1 || imem_addr !== 32'(w * 4) || imem_wd !== exp_wd) begin
                    errors++;
                    $display("FAIL full_word%0d: got we %b addr %h wd %h expected we 1 addr %h wd %h",
                             w, imem_we, imem_addr, imem_wd, 32'(w * 4), exp_wd);
                end
            end
            drive(0, 1, csum, 0);
            checks++;
            if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || imem_we !== 1'b0) begin
                errors++;
                $display("FAIL full_done: got done %b cpu_rst %b err %b we %b expected 1 0 0 0",
                         done, cpu_reset, error, imem_we);
            end
            drive(0, 0, 8'h00, 1);
            checks++;
            if (done !== 1'b0 || cpu_reset !== 1'b1 || rx_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_reload: got done %b cpu_rst %b rdy %b expected 0 1 1",
                         done, cpu_reset, rx_ready);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the instruction memory. It receives a framed byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. Each word goes into the imem write port at consecutive word addresses, and the loader holds the processor in reset until a complete, checksum-verified image is in place. This replaces the simulation-only hex preload with a synthesizable load path.

## Interface
- DEPTH, 64: imem capacity in words; largest legal word count.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- rx_valid  in  1  upstream byte valid.
- rx_data  in  8  upstream byte.
- rx_ready  out  1  loader accepts byte; transfer occurs on posedge when rx_valid & rx_ready.
- reload  in  1  single-cycle pulse; restarts loading from DONE or ERROR.
- imem_we  out  1  imem write enable, one-cycle pulse per word.
- imem_addr  out  32  byte address, always word-aligned (bits 1:0 = 0).
- imem_wd  out  32  word to write.
- cpu_reset  out  1  processor reset; high until image verified.
- done  out  1  image loaded and checksum matched.
- error  out  1  framing or checksum failure.

## Operation
- Frame format: CNT_LO, CNT_HI, then N×4 payload bytes, then CSUM.
  - N = {CNT_HI, CNT_LO}.
  - Each word is sent least-significant byte first.
  - CSUM = sum of all payload bytes mod 256. Header bytes are excluded.
- States:
  - HDR0: accept CNT_LO; go to HDR1.
  - HDR1: accept CNT_HI. If N == 0 or N > DEPTH, go to ERROR. Otherwise go to DATA with word index 0 and byte index 0.
  - DATA: accept a byte, add it to the running sum, and shift it into the packer at lane byte index.
    - On the 4th byte, issue a write for word index and advance word index.
    - After word N-1 completes, go to CSUM.
  - CSUM: accept a byte. Go to DONE if it equals the running sum, else go to ERROR.
  - DONE: done=1, cpu_reset=0. reload goes to HDR0 and raises cpu_reset.
  - ERROR: error=1, cpu_reset=1. reload goes to HDR0.
- rx_ready = 1 in HDR0, HDR1, DATA and CSUM; 0 in DONE and ERROR. It is a combinational decode of state.
- reload is ignored in all states except DONE and ERROR.
- When leaving DONE or ERROR via reload, clear the running sum, word index, byte index, done and error.
- Words already written are not erased on ERROR or reload. cpu_reset keeps the processor from executing them.
- Width rules:
  - Word count: 16 bits. Word index: clog2(DEPTH)+1 bits.
  - Running sum: 8 bits, wraps modulo 256.
  - imem_addr = {word index, 2'b00}, zero-extended to 32 bits.

## Timing
- Reset values:
  - state HDR0; rx_ready 1 once reset deasserts.
  - imem_we 0, imem_addr 0, imem_wd 0.
  - cpu_reset 1, done 0, error 0.
  - Running sum, word index and byte index all 0.
- Write latency: imem_we, imem_addr and imem_wd are registered.
  - They are valid the cycle after the 4th byte of a word is accepted.
  - imem_we is high for exactly one cycle.
- Throughput: one byte per cycle, no bubbles.
  - rx_ready stays high during the write cycle.
  - A CSUM byte accepted in the same cycle as the final imem_we is legal.
- Completion: done rises and cpu_reset falls the cycle after the matching CSUM byte is accepted.
  - This is always at or after the final write cycle.
- Header rejection: error rises the cycle after CNT_HI is accepted when N == 0 or N > DEPTH. No imem_we occurs.
- reload effect: cpu_reset rises and done/error fall the cycle after reload is sampled high. rx_ready is high that same cycle.
- Reset mid-load: takes effect on the next posedge and overrides all other inputs.
  - A pending imem_we is dropped.
  - State returns to HDR0 and all outputs return to their reset values.
- rx_valid with rx_ready low is not a transfer. rx_data is ignored.

## Structure
- Package loader_pkg holds:
  - enum typedef loader_state_t {HDR0, HDR1, DATA, CSUM, DONE, ERROR};
  - constant HDR_BYTES = 2;
  - constant BYTES_PER_WORD = 4.
- Sub-module byte_packer holds the 32-bit shift register, the 2-bit byte index and the word_ready pulse.
  - Inputs: clk, reset, clear, push, byte.
- The top level holds the FSM, word counter, checksum accumulator and output registers.

## Test plan
- Single word. Bytes 01 00 07 00 A0 E3 8A.
  - One imem_we with addr 0x0, wd 0xE3A00007.
  - Then done=1, cpu_reset=0.
- Two words, back-to-back rx_valid. Bytes 02 00 07 00 A0 E3 64 00 80 E5 53.
  - Writes (0x0, 0xE3A00007) then (0x4, 0xE5800064), 4 cycles apart.
  - done=1.
- Bad checksum. The two-word frame with last byte 54.
  - Both writes occur, then error=1, done=0, cpu_reset stays 1.
  - rx_ready=0 afterwards.
- Illegal count. Headers 00 00 and 41 00 (N=65 with DEPTH=64).
  - error=1 the cycle after CNT_HI; no imem_we; rx_ready=0.
- Gapped valid, then reload. Single-word frame with rx_valid toggled every other cycle.
  - Result matches the single-word case.
  - After done, pulse reload: cpu_reset=1, done=0, rx_ready=1 next cycle. A second frame loads correctly.
- Reset mid-load. Assert reset after 3 payload bytes.
  - No imem_we; state returns to HDR0; outputs at reset values.
  - A fresh frame then loads correctly.
